bram_fifo: RTL and testbench

- Synchronous first-word-fall-through FIFO built on one SB_RAM40_4K block RAM in 256x16 mode (WRITE_MODE=0, READ_MODE=0, MASK tied to 0).
- Acts as the access controller for the block RAM: generates the write and read ports, and manages the RAM's one-cycle registered read latency.
- Used to buffer pulse and sample words between the front-end decoders and the consumer.
- Valid/ready handshake on both sides.

---
 rtl/bram_fifo_pkg.sv | 18 +
 rtl/bram_fifo_ram.sv | 74 +++++++
 rtl/bram_fifo.sv | 151 +++++++++++++++
 tb/tb_bram_fifo.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_fifo_pkg.sv
// -----------------------------------------------------------------------------
// bram_fifo_pkg
// Shared constants for the block-RAM FIFO: geometry of one SB_RAM40_4K used
// in 256x16 mode, and a helper for sizing wrap-bit pointers.
// -----------------------------------------------------------------------------
package bram_fifo_pkg;

    // SB_RAM40_4K in 256x16 configuration
    localparam int unsigned BRAM_ADDR_W      = 8;
    localparam int unsigned BRAM_DATA_W      = 16;
    localparam int unsigned BRAM_MODE_256X16 = 0;

    // Pointer width: address bits plus one wrap bit to tell full from empty
    function automatic int unsigned ptr_w(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage : bram_fifo_pkg

// File: rtl/bram_fifo_ram.sv
// -----------------------------------------------------------------------------
// bram_fifo_ram
// Behavioural equivalent of one SB_RAM40_4K block RAM in 256x16 mode
// (WRITE_MODE = READ_MODE = 0). Both ports share one clock. The read port
// has one cycle of registered latency: rdata updates only on edges where
// re & rclke are high, and otherwise holds its last value.
//
// Ports:
//   clk    in   shared RCLK/WCLK
//   wclke  in   write clock enable
//   we     in   write enable
//   waddr  in   write address (8 bits)
//   wdata  in   write data (16 bits)
//   mask   in   per-bit write mask, 1 = bit not written
//   rclke  in   read clock enable
//   re     in   read enable
//   raddr  in   read address (8 bits)
//   rdata  out  registered read data (16 bits)
// -----------------------------------------------------------------------------
module bram_fifo_ram
    import bram_fifo_pkg::*;
#(
    parameter int unsigned WRITE_MODE = BRAM_MODE_256X16,
    parameter int unsigned READ_MODE  = BRAM_MODE_256X16
) (
    input  logic                   clk,
    input  logic                   wclke,
    input  logic                   we,
    input  logic [BRAM_ADDR_W-1:0] waddr,
    input  logic [BRAM_DATA_W-1:0] wdata,
    input  logic [BRAM_DATA_W-1:0] mask,
    input  logic                   rclke,
    input  logic                   re,
    input  logic [BRAM_ADDR_W-1:0] raddr,
    output logic [BRAM_DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << BRAM_ADDR_W;

    // Only the 256x16 geometry is modelled; any other mode leaves ports idle
    localparam bit MODE_OK = (WRITE_MODE == BRAM_MODE_256X16) &&
                             (READ_MODE  == BRAM_MODE_256X16);

    logic [BRAM_DATA_W-1:0] mem [DEPTH];
    logic [BRAM_DATA_W-1:0] rdata_q;
    logic                   wr_en_c;
    logic                   rd_en_c;

    always_comb begin
        wr_en_c = MODE_OK & wclke & we;
        rd_en_c = MODE_OK & rclke & re;
    end

    // Write port with bitwise mask
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int i = 0; i < int'(BRAM_DATA_W); i++) begin
                if (!mask[i]) begin
                    mem[waddr][i] <= wdata[i];
                end
            end
        end
    end

    // Registered read port; holds value when not enabled
    always_ff @(posedge clk) begin
        if (rd_en_c) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule : bram_fifo_ram

// File: rtl/bram_fifo.sv
// -----------------------------------------------------------------------------
// bram_fifo
// First-word-fall-through FIFO on a single SB_RAM40_4K (256x16). Controls
// both RAM ports and hides the one-cycle registered read latency: the head
// word is read into RAM RDATA ahead of the consumer and presented directly
// as out_data. Capacity is 2**ADDR_W words counting the head word.
//
// Ports:
//   clk          in   clock for all logic and both RAM ports
//   reset        in   synchronous active-high reset
//   clear        in   synchronous flush, same effect as reset on FIFO state
//   in_data      in   write word
//   in_valid     in   producer offers in_data
//   in_ready     out  FIFO accepts (push = in_valid & in_ready)
//   out_data     out  head word, straight from RAM RDATA
//   out_valid    out  out_data holds the head word
//   out_ready    in   consumer takes (pop = out_valid & out_ready)
//   level        out  entries held, including the head word
//   almost_full  out  level >= AFULL_LEVEL
// -----------------------------------------------------------------------------
module bram_fifo
    import bram_fifo_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned AFULL_LEVEL = 240
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic              almost_full
);

    localparam int unsigned PTR_W = ptr_w(ADDR_W);
    localparam logic [PTR_W-1:0] CAPACITY    = PTR_W'(1) << ADDR_W;
    localparam logic [PTR_W-1:0] AFULL_THRESH = PTR_W'(AFULL_LEVEL);

    logic [PTR_W-1:0] wptr_q,  wptr_d;
    logic [PTR_W-1:0] rptr_q,  rptr_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic             out_valid_q,   out_valid_d;
    logic             almost_full_q, almost_full_d;

    logic             in_ready_c;
    logic             push_c;
    logic             pop_c;
    logic             re_c;
    logic             ram_not_empty_c;

    logic [BRAM_DATA_W-1:0] ram_rdata;

    // Handshake decode; clear and reset suppress both RAM ports
    always_comb begin
        in_ready_c      = !reset && (level_q != CAPACITY);
        push_c          = in_valid && in_ready_c && !clear;
        pop_c           = out_valid_q && out_ready && !clear && !reset;
        // Only registered pointers gate the read, so a word is never read
        // in the same cycle it is written.
        ram_not_empty_c = (wptr_q != rptr_q);
        // Read only when the head slot is empty or being vacated; this
        // keeps RDATA frozen while the consumer stalls.
        re_c            = !reset && !clear && ram_not_empty_c &&
                          (!out_valid_q || out_ready);
    end

    // Next-state for pointers, head-valid flag and occupancy
    always_comb begin
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        level_d       = level_q;
        out_valid_d   = out_valid_q;
        almost_full_d = almost_full_q;

        if (push_c) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (re_c) begin
            rptr_d = rptr_q + PTR_W'(1);
        end

        if (re_c) begin
            out_valid_d = 1'b1;
        end else if (pop_c) begin
            out_valid_d = 1'b0;
        end

        unique case ({push_c, pop_c})
            2'b10:   level_d = level_q + PTR_W'(1);
            2'b01:   level_d = level_q - PTR_W'(1);
            default: level_d = level_q;
        endcase

        almost_full_d = (level_d >= AFULL_THRESH);

        if (clear) begin
            wptr_d        = '0;
            rptr_d        = '0;
            level_d       = '0;
            out_valid_d   = 1'b0;
            almost_full_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            level_q       <= '0;
            out_valid_q   <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            level_q       <= level_d;
            out_valid_q   <= out_valid_d;
            almost_full_q <= almost_full_d;
        end
    end

    // Block RAM; upper address and data bits tied to zero
    bram_fifo_ram #(
        .WRITE_MODE (BRAM_MODE_256X16),
        .READ_MODE  (BRAM_MODE_256X16)
    ) u_ram (
        .clk   (clk),
        .wclke (1'b1),
        .we    (push_c),
        .waddr (BRAM_ADDR_W'(wptr_q[ADDR_W-1:0])),
        .wdata (BRAM_DATA_W'(in_data)),
        .mask  ('0),
        .rclke (1'b1),
        .re    (re_c),
        .raddr (BRAM_ADDR_W'(rptr_q[ADDR_W-1:0])),
        .rdata (ram_rdata)
    );

    assign in_ready    = in_ready_c;
    assign out_data    = ram_rdata[DATA_W-1:0];
    assign out_valid   = out_valid_q;
    assign level       = level_q;
    assign almost_full = almost_full_q;

endmodule : bram_fifo

// File: tb/tb_bram_fifo.sv
// -----------------------------------------------------------------------------
// tb_bram_fifo
// Scoreboard bench for bram_fifo at default parameters (256 x 16, afull 240).
// -----------------------------------------------------------------------------
module tb_bram_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [8:0]  level;
    logic        almost_full;

    always #5 clk = ~clk;

    bram_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .almost_full (almost_full)
    );

    int          total = 0;
    int          bad   = 0;
    logic [15:0] sb[$];

    // Values observed just before the edge of the most recent step
    logic        s_pushed, s_popped, s_ov, s_ir, s_has;
    logic [15:0] s_got, s_exp;

    // One clock: drive inputs, sample handshakes before the edge, update the
    // scoreboard, then return 1 time unit after the edge.
    task automatic step(input logic iv, input logic [15:0] d, input logic ordy,
                        input logic clr, input logic rst);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        clear     = clr;
        reset     = rst;
        #1;
        s_ir     = in_ready;
        s_ov     = out_valid;
        s_got    = out_data;
        s_pushed = iv && in_ready && !clr && !rst;
        s_popped = out_valid && ordy && !clr && !rst;
        s_has    = 1'b0;
        s_exp    = 'x;
        if (s_popped && sb.size() != 0) begin
            s_has = 1'b1;
            s_exp = sb.pop_front();
        end
        if (s_pushed) sb.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        total++; if (s_ir !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", s_ir); end
        total++; if (level !== 9'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_afull got=%b want=0", almost_full); end
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_single();
        step(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b want=0", out_valid); end
        total++; if (level !== 9'd1) begin bad++; $display("FAIL single_level1 got=%0d want=1", level); end
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", out_valid); end
        total++; if (out_data !== 16'h1234) begin bad++; $display("FAIL single_data got=%h want=1234", out_data); end
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        total++; if (!s_popped || !s_has || s_got !== s_exp) begin bad++; $display("FAIL single_pop popped=%b got=%h want=%h", s_popped, s_got, s_exp); end
        total++; if (level !== 9'd0) begin bad++; $display("FAIL single_level0 got=%0d want=0", level); end
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL single_after valid=%b ready=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_fill_drain();
        int got_n = 0;
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
            total++; if (!s_pushed) begin bad++; $display("FAIL fill_accept i=%0d got=0 want=1", i); end
            total++; if (level !== 9'(i + 1)) begin bad++; $display("FAIL fill_level got=%0d want=%0d", level, i + 1); end
            total++; if (almost_full !== ((i + 1) >= 240)) begin bad++; $display("FAIL fill_afull level=%0d got=%b want=%b", i + 1, almost_full, (i + 1) >= 240); end
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
        step(1'b1, 16'h01FF, 1'b0, 1'b0, 1'b0);
        total++; if (s_pushed !== 1'b0) begin bad++; $display("FAIL full_reject got=%b want=0", s_pushed); end
        total++; if (level !== 9'd256) begin bad++; $display("FAIL full_level got=%0d want=256", level); end
        for (int c = 0; c < 300 && got_n < 256; c++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
            total++;
            if (!s_popped || !s_has || s_got !== s_exp) begin
                bad++; $display("FAIL drain_word n=%0d popped=%b got=%h want=%h", got_n, s_popped, s_got, s_exp);
            end
            if (s_popped) got_n++;
        end
        total++; if (got_n != 256) begin bad++; $display("FAIL drain_count got=%0d want=256", got_n); end
        total++; if (level !== 9'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty level=%0d valid=%b want 0/0", level, out_valid); end
    endtask

    task automatic test_stream();
        int gaps = 0;
        int lvl_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 16'(16'h4000 + i), 1'b1, 1'b0, 1'b0);
            if (s_popped) begin
                total++;
                if (!s_has || s_got !== s_exp) begin bad++; $display("FAIL stream_data i=%0d got=%h want=%h", i, s_got, s_exp); end
            end
            if (i >= 3 && !s_popped) gaps++;
            if (i >= 3 && level !== 9'd2) lvl_bad++;
        end
        total++; if (gaps != 0) begin bad++; $display("FAIL stream_gaps got=%0d want=0", gaps); end
        total++; if (lvl_bad != 0) begin bad++; $display("FAIL stream_level bad_cycles=%0d want=0", lvl_bad); end
        for (int c = 0; c < 10 && (sb.size() != 0 || out_valid); c++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
            if (s_popped) begin
                total++;
                if (!s_has || s_got !== s_exp) begin bad++; $display("FAIL stream_tail got=%h want=%h", s_got, s_exp); end
            end
        end
        total++; if (sb.size() != 0 || level !== 9'd0) begin bad++; $display("FAIL stream_empty left=%0d level=%0d want 0/0", sb.size(), level); end
    endtask

    task automatic test_backpressure();
        logic        prev_stall = 1'b0;
        logic [15:0] prev_data  = '0;
        logic        iv, ordy;
        int          sent = 0;
        int          rcvd = 0;
        for (int i = 0; i < 1500; i++) begin
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 3);
            step(iv, 16'(16'h8000 + sent), ordy, 1'b0, 1'b0);
            if (s_pushed) sent++;
            if (prev_stall && s_ov) begin
                total++;
                if (s_got !== prev_data) begin bad++; $display("FAIL hold_stable i=%0d got=%h want=%h", i, s_got, prev_data); end
            end
            if (s_popped) begin
                rcvd++;
                total++;
                if (!s_has || s_got !== s_exp) begin bad++; $display("FAIL bp_data i=%0d got=%h want=%h", i, s_got, s_exp); end
            end
            prev_stall = s_ov && !ordy;
            prev_data  = s_got;
        end
        for (int c = 0; c < 300 && (sb.size() != 0 || out_valid); c++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
            if (s_popped) begin
                rcvd++;
                total++;
                if (!s_has || s_got !== s_exp) begin bad++; $display("FAIL bp_tail got=%h want=%h", s_got, s_exp); end
            end
        end
        total++; if (rcvd != sent || sb.size() != 0) begin bad++; $display("FAIL bp_count got=%0d want=%0d", rcvd, sent); end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 100; i++) step(1'b1, 16'(16'h3000 + i), 1'b0, 1'b0, 1'b0);
        total++; if (level !== 9'd100) begin bad++; $display("FAIL clear_prelevel got=%0d want=100", level); end
        step(1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b0);
        sb.delete();
        total++; if (s_ir !== 1'b1) begin bad++; $display("FAIL clear_in_ready_during got=%b want=1", s_ir); end
        total++; if (level !== 9'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL clear_after level=%0d valid=%b ready=%b want 0/0/1", level, out_valid, in_ready);
        end
        step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clear_early_valid got=%b want=0", out_valid); end
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        total++; if (out_valid !== 1'b1 || out_data !== 16'hBEEF) begin
            bad++; $display("FAIL clear_head valid=%b data=%h want 1/beef", out_valid, out_data);
        end
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        total++; if (!s_popped || !s_has || s_got !== s_exp) begin bad++; $display("FAIL clear_pop got=%h want=%h", s_got, s_exp); end
        total++; if (level !== 9'd0) begin bad++; $display("FAIL clear_final_level got=%0d want=0", level); end
    endtask

    task automatic test_reset_mid();
        int rcvd = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b1, 16'(16'h6000 + i), ($urandom_range(0, 1) == 1), 1'b0, 1'b0);
            if (s_popped) begin
                total++;
                if (!s_has || s_got !== s_exp) begin bad++; $display("FAIL mid_pre_data got=%h want=%h", s_got, s_exp); end
            end
        end
        for (int r = 0; r < 3; r++) begin
            step(1'b1, 16'hBAD0, 1'b1, 1'b0, 1'b1);
            total++; if (s_ir !== 1'b0) begin bad++; $display("FAIL mid_reset_ready r=%0d got=%b want=0", r, s_ir); end
        end
        sb.delete();
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        total++; if (s_ov !== 1'b0 || level !== 9'd0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL mid_after_reset pre_valid=%b level=%0d valid=%b want 0/0/0", s_ov, level, out_valid);
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 16'(16'h5000 + k), 1'b1, 1'b0, 1'b0);
            if (s_popped) begin
                rcvd++; total++;
                if (!s_has || s_got !== s_exp) begin bad++; $display("FAIL mid_stale got=%h want=%h", s_got, s_exp); end
            end
        end
        for (int c = 0; c < 20 && (sb.size() != 0 || out_valid); c++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
            if (s_popped) begin
                rcvd++; total++;
                if (!s_has || s_got !== s_exp) begin bad++; $display("FAIL mid_stale_tail got=%h want=%h", s_got, s_exp); end
            end
        end
        total++; if (rcvd != 5) begin bad++; $display("FAIL mid_count got=%0d want=5", rcvd); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_stream();
        test_backpressure();
        test_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_bram_fifo
